ysyx_22040125_wb_arb: RTL and testbench
=======================================

Name: ysyx_22040125_wb_arb

Overview:
- Writeback arbiter and scoreboard directly upstream of the integer register file.
- Merges two result streams into the register file's single write port (en/addr_rd/data_rd):
  - single-cycle EXU results (source A, no backpressure);
  - long-latency MDU/LSU results (source B, valid/ready, buffered in a small FIFO).
- Keeps per-register busy bits for outstanding long-latency ops so decode can stall on RAW/WAW hazards.

Parameters:
XLEN, 64, datapath width
FIFO_DEPTH, 2, source-B buffer entries; power of two, >=2

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous, active-high reset
a_valid  in  1  EXU result valid this cycle; always accepted
a_rd  in  5  EXU destination register
a_data  in  XLEN  EXU result
b_valid  in  1  long-latency result valid
b_ready  out  1  arbiter can accept source-B result
b_rd  in  5  long-latency destination register
b_data  in  XLEN  long-latency result
mark_valid  in  1  decode issued a long-latency op
mark_rd  in  5  its destination register
addr_rs1  in  5  decode source 1 query
addr_rs2  in  5  decode source 2 query
rs1_busy  out  1  addr_rs1 has a pending long-latency write
rs2_busy  out  1  addr_rs2 has a pending long-latency write
en  out  1  register-file write enable (registered)
addr_rd  out  5  register-file write address (registered)
data_rd  out  XLEN  register-file write data (registered)

Behaviour:
- Reset (async, immediate):
  - en=0, addr_rd=0, data_rd=0.
  - FIFO emptied, pointers/count=0, all busy bits 0, internal out_is_b=0.
  - b_ready=0 while rst high.
  - Reset mid-operation discards buffered B results and pending busy state.
- b_ready = (count < FIFO_DEPTH). Combinational from registered count only; no path from b_valid or a_valid.
- Per-cycle selection, registered to outputs at next posedge (1-cycle latency), priority high to low:
  1. a_valid: output A; out_is_b=0.
  2. FIFO non-empty: pop head, output it; out_is_b=1.
  3. b_valid && b_ready with FIFO empty: bypass B directly to output; out_is_b=1; no push.
  4. Otherwise: en=0 next cycle.
- Push: b_valid && b_ready and the beat is not bypassed. Entry goes to the tail.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- B beats are never reordered.
- B may be starved indefinitely while a_valid stays high; this is intended.
- rd==0: the selected beat is consumed/popped normally, but the registered en=0. addr_rd/data_rd still update.
- Scoreboard (32 bits; bit 0 hard 0):
  - Set: mark_valid && mark_rd!=0 sets busy[mark_rd] at next edge.
  - Clear: on any edge where registered en=1 and out_is_b=1, busy[addr_rd] clears. This is the same edge the register file captures the data, so no forwarding is required.
  - Same-edge set and clear of the same index: set wins.
- rs1_busy = busy[addr_rs1], rs2_busy = busy[addr_rs2]; combinational, 0 for index 0.
- Precondition (guaranteed by decode stall, not checked here): no A write targets a busy register.

Test Plan:
- Reset, then idle -> en=0, b_ready=1, rs1_busy=rs2_busy=0.
- a_valid=1, a_rd=5, a_data=0x1234 for one cycle -> next cycle en=1, addr_rd=5, data_rd=0x1234; following cycle en=0.
- mark rd=7; later b beat rd=7, data=0xDEAD with FIFO empty and a_valid=0 -> rs1_busy (addr_rs1=7) =1 until output cycle; en=1/addr_rd=7/data_rd=0xDEAD one cycle after the handshake; busy[7]=0 the cycle after.
- Hold a_valid=1 for 4 cycles; offer B beats rd=3,4,5 -> first two accepted, then b_ready=0; after a_valid drops, outputs rd=3 then rd=4 on consecutive cycles, then b_ready=1 and rd=5 is accepted.
- mark_rd=9 on the same edge that a B write to rd=9 retires -> busy[9] remains 1.
- B beat rd=0 data=0xFF, then assert rst with one B beat buffered -> the rd=0 beat gives en=0 with no busy change; after rst, en=0, FIFO empty, all busy bits clear.

Source files
------------

// File: rtl/ysyx_22040125_wb_arb_if.sv
// Bundle of the writeback arbiter's bus signals: two result sources, the busy-bit
// scoreboard mark/query ports and the single register-file write port.
interface ysyx_22040125_wb_arb_if #(
    parameter int XLEN = 64
);
    // Source B handshake: a beat transfers on a clock edge where b_valid && b_ready;
    // b_ready never depends on b_valid, and source A has no ready (always accepted).
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            mark_valid;
    logic [4:0]      mark_rd;
    logic [4:0]      addr_rs1;
    logic [4:0]      addr_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            en;
    logic [4:0]      addr_rd;
    logic [XLEN-1:0] data_rd;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  mark_valid, mark_rd, addr_rs1, addr_rs2,
        output b_ready, rs1_busy, rs2_busy, en, addr_rd, data_rd
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output mark_valid, mark_rd, addr_rs1, addr_rs2,
        input  b_ready, rs1_busy, rs2_busy, en, addr_rd, data_rd
    );
endinterface

// File: rtl/ysyx_22040125_wb_arb.sv
// Writeback arbiter: merges single-cycle EXU results (A) and buffered long-latency
// results (B) into one registered register-file write port, and tracks busy registers.
module ysyx_22040125_wb_arb #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_22040125_wb_arb_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } beat_t;

    beat_t           mem_q [FIFO_DEPTH];
    beat_t           mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     busy_q, busy_d;
    logic            en_q, en_d;
    logic [4:0]      addr_rd_q, addr_rd_d;
    logic [XLEN-1:0] data_rd_q, data_rd_d;
    logic            out_is_b_q, out_is_b_d;

    logic fifo_empty;
    logic b_fire;
    logic bypass;
    logic push;
    logic pop;

    assign bus.b_ready  = !rst && (count_q < CW'(FIFO_DEPTH));
    assign bus.rs1_busy = busy_q[bus.addr_rs1];
    assign bus.rs2_busy = busy_q[bus.addr_rs2];
    assign bus.en       = en_q;
    assign bus.addr_rd  = addr_rd_q;
    assign bus.data_rd  = data_rd_q;

    always_comb begin
        fifo_empty = (count_q == '0);
        b_fire     = bus.b_valid && bus.b_ready;
        pop        = !bus.a_valid && !fifo_empty;
        bypass     = !bus.a_valid && fifo_empty && b_fire;
        push       = b_fire && !bypass;

        en_d       = 1'b0;
        addr_rd_d  = addr_rd_q;
        data_rd_d  = data_rd_q;
        out_is_b_d = 1'b0;
        if (bus.a_valid) begin
            en_d      = (bus.a_rd != 5'd0);
            addr_rd_d = bus.a_rd;
            data_rd_d = bus.a_data;
        end else if (pop) begin
            en_d       = (mem_q[rd_ptr_q].rd != 5'd0);
            addr_rd_d  = mem_q[rd_ptr_q].rd;
            data_rd_d  = mem_q[rd_ptr_q].data;
            out_is_b_d = 1'b1;
        end else if (bypass) begin
            en_d       = (bus.b_rd != 5'd0);
            addr_rd_d  = bus.b_rd;
            data_rd_d  = bus.b_data;
            out_is_b_d = 1'b1;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{rd: bus.b_rd, data: bus.b_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Clear lands on the edge the register file captures the value; a new mark wins.
        busy_d = busy_q;
        if (en_q && out_is_b_q) begin
            busy_d[addr_rd_q] = 1'b0;
        end
        if (bus.mark_valid && (bus.mark_rd != 5'd0)) begin
            busy_d[bus.mark_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            en_q       <= 1'b0;
            addr_rd_q  <= '0;
            data_rd_q  <= '0;
            out_is_b_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            addr_rd_q  <= addr_rd_d;
            data_rd_q  <= data_rd_d;
            out_is_b_q <= out_is_b_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22040125_wb_arb.sv
// Directed bench for the writeback arbiter: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares every en=1 cycle.
module tb_ysyx_22040125_wb_arb;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_22040125_wb_arb_if #(.XLEN(XLEN)) bus ();

    ysyx_22040125_wb_arb #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [68:0] exp_q[$];

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the head of the expected queue.
    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            if (bus.en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write",
                             bus.addr_rd, bus.data_rd);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_beat", {bus.addr_rd, bus.data_rd}, e);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.a_valid    = 1'b0;
        bus.a_rd       = '0;
        bus.a_data     = '0;
        bus.b_valid    = 1'b0;
        bus.b_rd       = '0;
        bus.b_data     = '0;
        bus.mark_valid = 1'b0;
        bus.mark_rd    = '0;
        bus.addr_rs1   = '0;
        bus.addr_rs2   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", bus.en, 0);
        check("rst_b_ready", bus.b_ready, 0);
        check("rst_addr_rd", bus.addr_rd, 0);
        check("rst_data_rd", bus.data_rd, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_b_ready", bus.b_ready, 1);
        check("idle_en", bus.en, 0);
        check("idle_rs1_busy", bus.rs1_busy, 0);
        check("idle_rs2_busy", bus.rs2_busy, 0);

        // Single A write, then the port goes idle again.
        tick();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 64'h1234;
        exp_q.push_back({5'd5, 64'h1234});
        tick();
        bus.a_valid = 1'b0;
        tick();
        @(negedge clk);
        check("a_single_en_drop", bus.en, 0);

        // Mark rd 7, retire it through the bypass path.
        tick();
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd7; bus.addr_rs1 = 5'd7;
        tick();
        bus.mark_valid = 1'b0;
        @(negedge clk);
        check("busy7_after_mark", bus.rs1_busy, 1);
        tick();
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 64'hDEAD;
        exp_q.push_back({5'd7, 64'hDEAD});
        @(negedge clk);
        check("bypass_b_ready", bus.b_ready, 1);
        check("busy7_before_hs", bus.rs1_busy, 1);
        tick();
        bus.b_valid = 1'b0;
        @(negedge clk);
        check("busy7_during_write", bus.rs1_busy, 1);
        tick();
        @(negedge clk);
        check("busy7_cleared", bus.rs1_busy, 0);

        // A held for 4 cycles starves B; FIFO fills at two entries.
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.a_valid = 1'b1;
            bus.a_rd    = 5'(10 + i);
            bus.a_data  = 64'hA000 + 64'(i);
            exp_q.push_back({5'(10 + i), 64'hA000 + 64'(i)});
            bus.b_valid = 1'b1;
            bus.b_rd    = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd5;
            bus.b_data  = (i == 0) ? 64'hB3 : (i == 1) ? 64'hB4 : 64'hB5;
            @(negedge clk);
            check($sformatf("starve_b_ready_%0d", i), bus.b_ready, (i < 2) ? 1 : 0);
        end
        exp_q.push_back({5'd3, 64'hB3});
        exp_q.push_back({5'd4, 64'hB4});
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("drain_b_ready_full", bus.b_ready, 0);
        tick();
        exp_q.push_back({5'd5, 64'hB5});
        @(negedge clk);
        check("drain_b_ready_reopen", bus.b_ready, 1);
        tick();
        bus.b_valid = 1'b0;
        tick();
        tick();

        // Mark of rd 9 on the same edge its previous write retires: set wins.
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd9; bus.addr_rs2 = 5'd9;
        tick();
        bus.mark_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 64'h99;
        exp_q.push_back({5'd9, 64'h99});
        tick();
        bus.b_valid = 1'b0;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd9;
        tick();
        bus.mark_valid = 1'b0;
        @(negedge clk);
        check("busy9_set_wins", bus.rs2_busy, 1);

        // B beat to x0: consumed with en low, address/data still update.
        tick();
        bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 64'hFF; bus.addr_rs1 = 5'd0;
        tick();
        bus.b_valid = 1'b0;
        @(negedge clk);
        check("rd0_en", bus.en, 0);
        check("rd0_addr_rd", bus.addr_rd, 0);
        check("rd0_data_rd", bus.data_rd, 64'hFF);
        check("rd0_rs1_busy", bus.rs1_busy, 0);
        check("rd0_busy9_kept", bus.rs2_busy, 1);

        // Buffer one B beat behind an A write, then reset mid-operation.
        tick();
        bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 64'h111;
        exp_q.push_back({5'd1, 64'h111});
        bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 64'h222;
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        check("buffered_b_ready", bus.b_ready, 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_en", bus.en, 0);
        check("async_rst_b_ready", bus.b_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        bus.addr_rs1 = 5'd7;
        bus.addr_rs2 = 5'd9;
        @(negedge clk);
        check("post_rst_en", bus.en, 0);
        check("post_rst_b_ready", bus.b_ready, 1);
        check("post_rst_busy9", bus.rs2_busy, 0);
        check("post_rst_busy7", bus.rs1_busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check($sformatf("post_rst_no_pop_%0d", i), bus.en, 0);
        end
        check("queue_drained", 69'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
